scaler_cfg_sequencer: RTL and testbench

Frame-synchronous configuration controller for the RGB bicubic scaler. Accepts configuration writes from the UART command decoder over a valid/ready handshake and holds them in staging registers. Validates each committed set and applies it atomically at the next input frame start (rising edge of `per_img_vsync`), so the scaler's `c_dst_img_width`, `c_dst_img_height`, `bi_a` and `out_model` never change mid-frame. Sits between the UART control path and the scaler top.

---
 rtl/scaler_cfg_sequencer_if.sv | 28 ++
 rtl/scaler_cfg_sequencer.sv | 164 ++++++++++++++++
 tb/tb_scaler_cfg_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/scaler_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : scaler_cfg_sequencer_if
// Brief    : Configuration write handshake between the UART decoder and the
//            scaler configuration sequencer.
// Revision : 1.0
// ============================================================================
interface scaler_cfg_sequencer_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_addr;
    logic [11:0] cfg_wdata;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/scaler_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scaler_cfg_sequencer
// Brief    : Stages scaler configuration writes, validates each committed
//            set and applies it atomically at the next input frame start.
// Revision : 1.0
// ============================================================================
module scaler_cfg_sequencer #(
    parameter logic [11:0] C_MAX_DST_WIDTH  = 12'd2560,
    parameter logic [11:0] C_MAX_DST_HEIGHT = 12'd1440,
    parameter logic [11:0] C_MIN_DST_DIM    = 12'd16,
    parameter logic [11:0] C_DEF_DST_WIDTH  = 12'd2560,
    parameter logic [11:0] C_DEF_DST_HEIGHT = 12'd1440,
    parameter logic [8:0]  C_DEF_BI_A       = 9'd128,
    parameter logic [23:0] C_TIMEOUT_CYCLES = 24'd2000000
) (
    input  wire logic               clk_in2,
    input  wire logic               rst,
    scaler_cfg_sequencer_if.slave   cfg,
    input  wire logic               per_img_vsync,
    output logic [11:0]             c_dst_img_width,
    output logic [11:0]             c_dst_img_height,
    output logic [8:0]              bi_a,
    output logic [1:0]              out_model,
    output logic                    apply_pulse,
    output logic                    cfg_pending,
    output logic                    cfg_err,
    output logic                    timeout_flag,
    output logic [15:0]             frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_vsync_d;
    logic        r_cfg_ready;
    logic [23:0] r_tmo_cnt;

    logic [11:0] r_stg_width;
    logic [11:0] r_stg_height;
    logic [8:0]  r_stg_bi_a;
    logic [1:0]  r_stg_model;

    logic        w_frame_start;
    logic        w_accept;
    logic        w_commit;
    logic        w_set_ok;
    logic        w_tmo_hit;
    logic        w_do_apply;

    assign w_frame_start = per_img_vsync & ~r_vsync_d;
    assign w_accept      = cfg.cfg_valid & r_cfg_ready;
    assign w_commit      = w_accept & (cfg.cfg_addr == 2'd3);
    assign w_set_ok      = (r_stg_width  >= C_MIN_DST_DIM) && (r_stg_width  <= C_MAX_DST_WIDTH) &&
                           (r_stg_height >= C_MIN_DST_DIM) && (r_stg_height <= C_MAX_DST_HEIGHT);
    assign w_tmo_hit     = (r_tmo_cnt == (C_TIMEOUT_CYCLES - 24'd1));
    assign w_do_apply    = (r_state == ST_WAIT) && (w_state_nxt == ST_APPLY);

    assign cfg.cfg_ready = r_cfg_ready;

    always_ff @(posedge clk_in2) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_commit && w_set_ok) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_frame_start || w_tmo_hit) begin
                    w_state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs are registered copies of the next state.
    always_ff @(posedge clk_in2) begin
        if (rst) begin
            r_vsync_d        <= 1'b0;
            r_cfg_ready      <= 1'b0;
            r_tmo_cnt        <= 24'd0;
            r_stg_width      <= C_DEF_DST_WIDTH;
            r_stg_height     <= C_DEF_DST_HEIGHT;
            r_stg_bi_a       <= C_DEF_BI_A;
            r_stg_model      <= 2'd0;
            c_dst_img_width  <= C_DEF_DST_WIDTH;
            c_dst_img_height <= C_DEF_DST_HEIGHT;
            bi_a             <= C_DEF_BI_A;
            out_model        <= 2'd0;
            apply_pulse      <= 1'b0;
            cfg_pending      <= 1'b0;
            cfg_err          <= 1'b0;
            timeout_flag     <= 1'b0;
            frame_cnt        <= 16'd0;
        end else begin
            r_vsync_d   <= per_img_vsync;
            r_cfg_ready <= (w_state_nxt == ST_IDLE);
            cfg_pending <= (w_state_nxt == ST_WAIT);
            apply_pulse <= (w_state_nxt == ST_APPLY);

            if (w_frame_start) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            if (r_state == ST_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 24'd1;
            end else begin
                r_tmo_cnt <= 24'd0;
            end

            if (w_accept) begin
                case (cfg.cfg_addr)
                    2'd0: r_stg_width  <= cfg.cfg_wdata;
                    2'd1: r_stg_height <= cfg.cfg_wdata;
                    2'd2: r_stg_bi_a   <= cfg.cfg_wdata[8:0];
                    default: begin
                        if (w_set_ok) begin
                            r_stg_model <= cfg.cfg_wdata[1:0];
                            cfg_err     <= 1'b0;
                        end else begin
                            // A rejected set is discarded so later partial writes start from what is live.
                            r_stg_width  <= c_dst_img_width;
                            r_stg_height <= c_dst_img_height;
                            r_stg_bi_a   <= bi_a;
                            r_stg_model  <= out_model;
                            cfg_err      <= 1'b1;
                        end
                    end
                endcase
            end

            if (w_do_apply) begin
                c_dst_img_width  <= r_stg_width;
                c_dst_img_height <= r_stg_height;
                bi_a             <= r_stg_bi_a;
                out_model        <= r_stg_model;
                timeout_flag     <= ~w_frame_start;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scaler_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scaler_cfg_sequencer
// Brief    : Directed self-checking bench for scaler_cfg_sequencer.
// Revision : 1.0
// ============================================================================
module tb_scaler_cfg_sequencer;

    logic        clk_in2 = 1'b0;
    logic        rst;
    logic        per_img_vsync;
    logic [11:0] c_dst_img_width;
    logic [11:0] c_dst_img_height;
    logic [8:0]  bi_a;
    logic [1:0]  out_model;
    logic        apply_pulse;
    logic        cfg_pending;
    logic        cfg_err;
    logic        timeout_flag;
    logic [15:0] frame_cnt;

    int n_total = 0;
    int n_pass  = 0;

    scaler_cfg_sequencer_if u_if ();

    scaler_cfg_sequencer #(
        .C_TIMEOUT_CYCLES (24'd100)
    ) u_dut (
        .clk_in2          (clk_in2),
        .rst              (rst),
        .cfg              (u_if.slave),
        .per_img_vsync    (per_img_vsync),
        .c_dst_img_width  (c_dst_img_width),
        .c_dst_img_height (c_dst_img_height),
        .bi_a             (bi_a),
        .out_model        (out_model),
        .apply_pulse      (apply_pulse),
        .cfg_pending      (cfg_pending),
        .cfg_err          (cfg_err),
        .timeout_flag     (timeout_flag),
        .frame_cnt        (frame_cnt)
    );

    always #5 clk_in2 = ~clk_in2;

    task automatic tick();
        @(posedge clk_in2);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_active(input string tag, input logic [11:0] w, input logic [11:0] h,
                                input logic [8:0] a, input logic [1:0] m);
        check({tag, "_width"},  32'(c_dst_img_width),  32'(w));
        check({tag, "_height"}, 32'(c_dst_img_height), 32'(h));
        check({tag, "_bi_a"},   32'(bi_a),             32'(a));
        check({tag, "_model"},  32'(out_model),        32'(m));
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [11:0] data);
        int waited;
        waited          = 0;
        u_if.cfg_valid  = 1'b1;
        u_if.cfg_addr   = addr;
        u_if.cfg_wdata  = data;
        while (!u_if.cfg_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) begin
            check("wr_ready_wait", 32'(u_if.cfg_ready), 32'd1);
        end
        tick();
        u_if.cfg_valid = 1'b0;
    endtask

    task automatic vsync_rise();
        per_img_vsync = 1'b1;
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        per_img_vsync  = 1'b0;
        u_if.cfg_valid = 1'b0;
        u_if.cfg_addr  = 2'd0;
        u_if.cfg_wdata = 12'd0;
        repeat (3) tick();
        check("rst_ready", 32'(u_if.cfg_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(u_if.cfg_ready), 32'd1);
        repeat (10) tick();
        check_active("idle", 12'd2560, 12'd1440, 9'd128, 2'd0);
        check("idle_pending", 32'(cfg_pending), 32'd0);
        check("idle_err", 32'(cfg_err), 32'd0);
        check("idle_tmo", 32'(timeout_flag), 32'd0);
        check("idle_apply", 32'(apply_pulse), 32'd0);
        check("idle_frame", 32'(frame_cnt), 32'd0);

        // Normal frame-synchronous apply
        cfg_write(2'd0, 12'd1920);
        cfg_write(2'd1, 12'd1080);
        cfg_write(2'd2, 12'd96);
        cfg_write(2'd3, 12'd2);
        check("commit_pending", 32'(cfg_pending), 32'd1);
        check("commit_ready", 32'(u_if.cfg_ready), 32'd0);
        repeat (5) tick();
        check_active("wait_hold", 12'd2560, 12'd1440, 9'd128, 2'd0);
        vsync_rise();
        check_active("apply1", 12'd1920, 12'd1080, 9'd96, 2'd2);
        check("apply1_pulse", 32'(apply_pulse), 32'd1);
        check("apply1_pending", 32'(cfg_pending), 32'd0);
        check("apply1_ready", 32'(u_if.cfg_ready), 32'd0);
        check("apply1_frame", 32'(frame_cnt), 32'd1);
        per_img_vsync = 1'b0;
        tick();
        check("apply1_pulse_fall", 32'(apply_pulse), 32'd0);
        check("apply1_ready_rise", 32'(u_if.cfg_ready), 32'd1);

        // Rejected commit restores staging from the active set
        cfg_write(2'd0, 12'd3000);
        cfg_write(2'd3, 12'd1);
        check("rej_err", 32'(cfg_err), 32'd1);
        check("rej_pending", 32'(cfg_pending), 32'd0);
        check("rej_ready", 32'(u_if.cfg_ready), 32'd1);
        cfg_write(2'd2, 12'd200);
        cfg_write(2'd3, 12'd3);
        check("recommit_err", 32'(cfg_err), 32'd0);
        check("recommit_pending", 32'(cfg_pending), 32'd1);
        vsync_rise();
        per_img_vsync = 1'b0;
        check_active("apply2", 12'd1920, 12'd1080, 9'd200, 2'd3);
        check("apply2_frame", 32'(frame_cnt), 32'd2);
        tick();

        // Boundary reject at max+1, boundary accept at min width / max height, timeout apply
        cfg_write(2'd0, 12'd2561);
        cfg_write(2'd3, 12'd0);
        check("rej2561_err", 32'(cfg_err), 32'd1);
        cfg_write(2'd0, 12'd16);
        cfg_write(2'd1, 12'd1440);
        cfg_write(2'd3, 12'd0);
        check("bound_err", 32'(cfg_err), 32'd0);
        check("bound_pending", 32'(cfg_pending), 32'd1);
        repeat (99) tick();
        check("tmo_pre_pending", 32'(cfg_pending), 32'd1);
        check("tmo_pre_apply", 32'(apply_pulse), 32'd0);
        tick();
        check("tmo_apply", 32'(apply_pulse), 32'd1);
        check("tmo_flag", 32'(timeout_flag), 32'd1);
        check_active("tmo", 12'd16, 12'd1440, 9'd200, 2'd0);
        tick();
        cfg_write(2'd1, 12'd720);
        cfg_write(2'd3, 12'd0);
        check("tmo_flag_sticky", 32'(timeout_flag), 32'd1);
        vsync_rise();
        per_img_vsync = 1'b0;
        check("tmo_flag_clear", 32'(timeout_flag), 32'd0);
        check_active("apply3", 12'd16, 12'd720, 9'd200, 2'd0);
        check("apply3_frame", 32'(frame_cnt), 32'd3);
        tick();

        // Commit coincident with vsync rise waits for the next frame
        cfg_write(2'd0, 12'd640);
        u_if.cfg_valid = 1'b1;
        u_if.cfg_addr  = 2'd3;
        u_if.cfg_wdata = 12'd1;
        per_img_vsync  = 1'b1;
        tick();
        u_if.cfg_valid = 1'b0;
        check("same_pending", 32'(cfg_pending), 32'd1);
        check("same_apply", 32'(apply_pulse), 32'd0);
        check("same_frame", 32'(frame_cnt), 32'd4);
        per_img_vsync = 1'b0;
        repeat (3) tick();
        check("same_hold_pending", 32'(cfg_pending), 32'd1);
        check("same_hold_width", 32'(c_dst_img_width), 32'd16);
        vsync_rise();
        per_img_vsync = 1'b0;
        check("same_apply2", 32'(apply_pulse), 32'd1);
        check_active("apply4", 12'd640, 12'd720, 9'd200, 2'd1);
        check("apply4_frame", 32'(frame_cnt), 32'd5);
        tick();

        // Reset during WAIT discards the pending set
        cfg_write(2'd0, 12'd800);
        cfg_write(2'd3, 12'd2);
        check("rstwait_pending", 32'(cfg_pending), 32'd1);
        rst = 1'b1;
        tick();
        check_active("rstwait", 12'd2560, 12'd1440, 9'd128, 2'd0);
        check("rstwait_pending0", 32'(cfg_pending), 32'd0);
        check("rstwait_frame", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check("rstwait_ready", 32'(u_if.cfg_ready), 32'd1);
        vsync_rise();
        per_img_vsync = 1'b0;
        check("rstwait_no_apply", 32'(apply_pulse), 32'd0);
        check("rstwait_frame1", 32'(frame_cnt), 32'd1);
        tick();
        check("rstwait_no_apply2", 32'(apply_pulse), 32'd0);
        check("rstwait_width", 32'(c_dst_img_width), 32'd2560);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
